// File: rtl/counter_clock_ctrl_pkg.sv
// Shared state encoding and default 50 MHz timing constants for the
// lab counter clock controller.
package counter_clock_ctrl_pkg;

   typedef enum logic [1:0] {
      PAUSED = 2'd0,
      RUN    = 2'd1,
      STEP   = 2'd2
   } state_e;

   localparam int unsigned DEF_DIV_HALF  = 25000000;
   localparam int unsigned DEF_CNT_W     = 25;
   localparam int unsigned DEF_DB_CYCLES = 500000;
   localparam int unsigned DEF_DB_W      = 19;

endpackage

// File: rtl/counter_clock_ctrl_button_conditioner.sv
// Raw active-low pushbutton -> 2-FF sync -> debounce -> one-clk press pulse
// on each accepted high-to-low transition.
module button_conditioner
   import counter_clock_ctrl_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DEF_DB_CYCLES,
   parameter int unsigned DB_W      = DEF_DB_W
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic press
);

   logic [1:0]      sync_q, sync_d;
   logic            level_q, level_d;
   logic [DB_W-1:0] cnt_q, cnt_d;
   logic            press_q, press_d;

   // Counter tracks consecutive synchronized samples that disagree with the
   // accepted level; any agreeing sample restarts the count.
   always_comb begin
      sync_d  = {sync_q[0], btn_n};
      level_d = level_q;
      cnt_d   = '0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == DB_W'(DB_CYCLES - 1))
            level_d = sync_q[1];
         else
            cnt_d = cnt_q + DB_W'(1);
      end
      press_d = level_q & ~level_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q  <= '1;
         level_q <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/counter_clock_ctrl.sv
// Slow count-clock generator with run / pause / single-step control from
// two debounced pushbuttons; provides both slow_clk and a matching tick.
module counter_clock_ctrl
   import counter_clock_ctrl_pkg::*;
#(
   parameter int unsigned DIV_HALF  = DEF_DIV_HALF,
   parameter int unsigned CNT_W     = DEF_CNT_W,
   parameter int unsigned DB_CYCLES = DEF_DB_CYCLES,
   parameter int unsigned DB_W      = DEF_DB_W
) (
   input  logic clk,
   input  logic rst,
   input  logic run_btn_n,
   input  logic step_btn_n,
   output logic slow_clk,
   output logic tick,
   output logic running
);

   logic             run_press, step_press;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic             slow_q, slow_d;
   logic             tick_q, tick_d;
   logic             running_q, running_d;
   logic             div_wrap;

   button_conditioner #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_run_btn (
      .clk   (clk),
      .rst   (rst),
      .btn_n (run_btn_n),
      .press (run_press)
   );

   button_conditioner #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_step_btn (
      .clk   (clk),
      .rst   (rst),
      .btn_n (step_btn_n),
      .press (step_press)
   );

   assign div_wrap = (div_q == CNT_W'(DIV_HALF - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= PAUSED;
         div_q     <= '0;
         slow_q    <= 1'b0;
         tick_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         slow_q    <= slow_d;
         tick_q    <= tick_d;
         running_q <= running_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         PAUSED: begin
            if (run_press)       state_d = RUN;
            else if (step_press) state_d = STEP;
         end
         RUN:     if (run_press) state_d = PAUSED;
         STEP:    if (div_wrap)  state_d = PAUSED;
         default: state_d = PAUSED;
      endcase
   end

   // Outputs are registered: tick is computed together with the slow_clk
   // rising transition so both appear on the same edge.
   always_comb begin
      div_d     = '0;
      slow_d    = 1'b0;
      tick_d    = 1'b0;
      running_d = (state_d == RUN);
      unique case (state_q)
         PAUSED: begin
            if (!run_press && step_press) begin
               slow_d = 1'b1;
               tick_d = 1'b1;
            end
         end
         RUN: begin
            if (!run_press) begin
               div_d  = div_wrap ? '0 : div_q + CNT_W'(1);
               slow_d = div_wrap ? ~slow_q : slow_q;
               tick_d = div_wrap & ~slow_q;
            end
         end
         STEP: begin
            if (!div_wrap) begin
               div_d  = div_q + CNT_W'(1);
               slow_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign slow_clk = slow_q;
   assign tick     = tick_q;
   assign running  = running_q;

endmodule

// File: tb/tb_counter_clock_ctrl.sv
// Directed bench for counter_clock_ctrl with DIV_HALF=4, DB_CYCLES=3:
// press-to-RUN latency is 6 edges, slow_clk period is 8.
module tb_counter_clock_ctrl;

   logic clk        = 1'b0;
   logic rst        = 1'b0;
   logic run_btn_n  = 1'b1;
   logic step_btn_n = 1'b1;
   logic slow_clk, tick, running;

   int tests    = 0;
   int fails    = 0;
   int tick_cnt = 0;
   int rise_cnt = 0;
   int run_chg  = 0;
   logic slow_prev = 1'b0;
   logic run_prev  = 1'b0;

   always #5 clk = ~clk;

   counter_clock_ctrl #(
      .DIV_HALF  (4),
      .CNT_W     (3),
      .DB_CYCLES (3),
      .DB_W      (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .run_btn_n  (run_btn_n),
      .step_btn_n (step_btn_n),
      .slow_clk   (slow_clk),
      .tick       (tick),
      .running    (running)
   );

   // Activity monitor sampled mid-cycle.
   always @(negedge clk) begin
      if (tick === 1'b1) tick_cnt++;
      if (slow_clk === 1'b1 && slow_prev === 1'b0) rise_cnt++;
      if (running !== run_prev) run_chg++;
      slow_prev = slow_clk;
      run_prev  = running;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      cyc(2);
      tests++; if (slow_clk !== 1'b0) begin fails++; $display("FAIL reset_slow: got %b want 0", slow_clk); end
      tests++; if (tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b want 0", tick); end
      tests++; if (running !== 1'b0) begin fails++; $display("FAIL reset_running: got %b want 0", running); end
      rst = 1'b1;
      cyc(10);
      tests++; if (running !== 1'b0 || slow_clk !== 1'b0) begin fails++; $display("FAIL idle_after_reset: running=%b slow=%b want 0 0", running, slow_clk); end
      tests++; if (tick_cnt !== 0) begin fails++; $display("FAIL idle_ticks: got %0d want 0", tick_cnt); end
   endtask

   task automatic test_run_press;
      int base, rbase;
      base = tick_cnt; rbase = rise_cnt;
      run_btn_n = 1'b0;
      cyc(5);
      tests++; if (running !== 1'b0) begin fails++; $display("FAIL run_latency_early: running=%b want 0", running); end
      cyc(1);
      tests++; if (running !== 1'b1) begin fails++; $display("FAIL run_entry: running=%b want 1", running); end
      tests++; if (slow_clk !== 1'b0) begin fails++; $display("FAIL run_entry_slow: got %b want 0", slow_clk); end
      cyc(3);
      tests++; if (tick !== 1'b0) begin fails++; $display("FAIL tick_early: got %b want 0", tick); end
      cyc(1);
      tests++; if (tick !== 1'b1 || slow_clk !== 1'b1) begin fails++; $display("FAIL first_tick: tick=%b slow=%b want 1 1", tick, slow_clk); end
      run_btn_n = 1'b1;
      cyc(3);
      tests++; if (slow_clk !== 1'b1) begin fails++; $display("FAIL slow_high_phase: got %b want 1", slow_clk); end
      cyc(1);
      tests++; if (slow_clk !== 1'b0) begin fails++; $display("FAIL slow_low_phase: got %b want 0", slow_clk); end
      cyc(35);
      tests++; if (tick_cnt - base !== 5) begin fails++; $display("FAIL ticks_in_40: got %0d want 5", tick_cnt - base); end
      tests++; if (rise_cnt - rbase !== 5) begin fails++; $display("FAIL rises_in_40: got %0d want 5", rise_cnt - rbase); end
   endtask

   task automatic test_pause_resume;
      int base;
      // Timed so the pause event lands inside a slow_clk high phase.
      cyc(5);
      run_btn_n = 1'b0;
      cyc(5);
      tests++; if (running !== 1'b1 || slow_clk !== 1'b1) begin fails++; $display("FAIL pre_pause: running=%b slow=%b want 1 1", running, slow_clk); end
      cyc(1);
      tests++; if (running !== 1'b0 || slow_clk !== 1'b0 || tick !== 1'b0) begin fails++; $display("FAIL pause_edge: running=%b slow=%b tick=%b want 0 0 0", running, slow_clk, tick); end
      base = tick_cnt;
      cyc(4);
      run_btn_n = 1'b1;
      cyc(16);
      tests++; if (tick_cnt !== base || slow_clk !== 1'b0 || running !== 1'b0) begin fails++; $display("FAIL paused_quiet: ticks=%0d slow=%b running=%b want %0d 0 0", tick_cnt, slow_clk, running, base); end
      run_btn_n = 1'b0;
      cyc(6);
      tests++; if (running !== 1'b1) begin fails++; $display("FAIL resume: running=%b want 1", running); end
      cyc(3);
      tests++; if (tick !== 1'b0) begin fails++; $display("FAIL resume_tick_early: got %b want 0", tick); end
      cyc(1);
      tests++; if (tick !== 1'b1) begin fails++; $display("FAIL resume_first_tick: got %b want 1", tick); end
      run_btn_n = 1'b1;
      cyc(6);
      run_btn_n = 1'b0;
      cyc(10);
      run_btn_n = 1'b1;
      cyc(8);
      tests++; if (running !== 1'b0 || slow_clk !== 1'b0) begin fails++; $display("FAIL repause: running=%b slow=%b want 0 0", running, slow_clk); end
   endtask

   task automatic test_bounce;
      int chg;
      chg = run_chg;
      for (int i = 0; i < 6; i++) begin
         run_btn_n = i[0];
         cyc(1);
      end
      run_btn_n = 1'b0;
      cyc(10);
      tests++; if (running !== 1'b1) begin fails++; $display("FAIL bounce_press: running=%b want 1", running); end
      tests++; if (run_chg - chg !== 1) begin fails++; $display("FAIL bounce_changes: got %0d want 1", run_chg - chg); end
      for (int i = 0; i < 6; i++) begin
         run_btn_n = ~i[0];
         cyc(1);
      end
      run_btn_n = 1'b1;
      cyc(12);
      tests++; if (running !== 1'b1 || run_chg - chg !== 1) begin fails++; $display("FAIL bounce_release: running=%b changes=%0d want 1 1", running, run_chg - chg); end
      run_btn_n = 1'b0;
      cyc(10);
      run_btn_n = 1'b1;
      cyc(8);
      tests++; if (running !== 1'b0) begin fails++; $display("FAIL bounce_pause: running=%b want 0", running); end
   endtask

   task automatic test_step;
      int base;
      base = tick_cnt;
      step_btn_n = 1'b0;
      cyc(2);
      // Run press event arrives while STEP is active and must be dropped.
      run_btn_n = 1'b0;
      cyc(3);
      tests++; if (slow_clk !== 1'b0) begin fails++; $display("FAIL step_early: slow=%b want 0", slow_clk); end
      cyc(1);
      tests++; if (slow_clk !== 1'b1 || tick !== 1'b1 || running !== 1'b0) begin fails++; $display("FAIL step_entry: slow=%b tick=%b running=%b want 1 1 0", slow_clk, tick, running); end
      cyc(1);
      tests++; if (tick !== 1'b0) begin fails++; $display("FAIL step_tick_once: got %b want 0", tick); end
      cyc(2);
      tests++; if (slow_clk !== 1'b1) begin fails++; $display("FAIL step_high_last: slow=%b want 1", slow_clk); end
      cyc(1);
      tests++; if (slow_clk !== 1'b0 || running !== 1'b0) begin fails++; $display("FAIL step_exit: slow=%b running=%b want 0 0", slow_clk, running); end
      cyc(2);
      step_btn_n = 1'b1;
      run_btn_n  = 1'b1;
      cyc(10);
      tests++; if (running !== 1'b0 || slow_clk !== 1'b0) begin fails++; $display("FAIL step_no_queue: running=%b slow=%b want 0 0", running, slow_clk); end
      tests++; if (tick_cnt - base !== 1) begin fails++; $display("FAIL step_tick_count: got %0d want 1", tick_cnt - base); end
   endtask

   task automatic test_simultaneous;
      int base;
      run_btn_n  = 1'b0;
      step_btn_n = 1'b0;
      cyc(6);
      tests++; if (running !== 1'b1 || slow_clk !== 1'b0 || tick !== 1'b0) begin fails++; $display("FAIL run_wins: running=%b slow=%b tick=%b want 1 0 0", running, slow_clk, tick); end
      cyc(4);
      run_btn_n  = 1'b1;
      step_btn_n = 1'b1;
      cyc(8);
      base = tick_cnt;
      step_btn_n = 1'b0;
      cyc(10);
      step_btn_n = 1'b1;
      cyc(30);
      tests++; if (running !== 1'b1) begin fails++; $display("FAIL step_in_run: running=%b want 1", running); end
      tests++; if (tick_cnt - base !== 5) begin fails++; $display("FAIL step_in_run_ticks: got %0d want 5", tick_cnt - base); end
   endtask

   task automatic test_reset_mid_run;
      int n;
      int base;
      n = 0;
      while (slow_clk !== 1'b1 && n < 16) begin
         cyc(1);
         n++;
      end
      tests++; if (slow_clk !== 1'b1) begin fails++; $display("FAIL wait_slow_high: timed out, slow=%b want 1", slow_clk); end
      #2;
      rst = 1'b0;
      #1;
      tests++; if (slow_clk !== 1'b0 || tick !== 1'b0 || running !== 1'b0) begin fails++; $display("FAIL async_reset: slow=%b tick=%b running=%b want 0 0 0", slow_clk, tick, running); end
      cyc(2);
      rst = 1'b1;
      base = tick_cnt;
      cyc(20);
      tests++; if (running !== 1'b0 || slow_clk !== 1'b0 || tick_cnt !== base) begin fails++; $display("FAIL post_reset_idle: running=%b slow=%b ticks=%0d want 0 0 %0d", running, slow_clk, tick_cnt, base); end
      tests++; if (tick_cnt !== rise_cnt) begin fails++; $display("FAIL tick_vs_rise: ticks=%0d rises=%0d", tick_cnt, rise_cnt); end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_run_press();
      test_pause_resume();
      test_bounce();
      test_step();
      test_simultaneous();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
